// File: rtl/irq_ctrl.sv
// Vectored interrupt controller for the RISC5 CPU: edge-detected sources, mask,
// global enable, fixed priority (bit 0 highest) and in-service tracking via intack/rti.
module irq_ctrl #(
  parameter int unsigned num_irq = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stb,
  input  logic               we,
  input  logic               addr,
  input  logic [31:0]        data_in,
  input  logic [num_irq-1:0] src,
  input  logic               intack,
  input  logic               rti,
  output logic [31:0]        data_out,
  output logic               ack,
  output logic               irq,
  output logic [2:0]         cur_src
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << num_irq) - 9'd1);

  logic [num_irq-1:0] s1_q, s2_q, s3_q;
  logic [7:0]         mask_q, mask_d;
  logic [7:0]         pend_q, pend_d;
  logic               gen_q, gen_d;
  logic               insvc_q, insvc_d;
  logic               spur_q, spur_d;
  logic [2:0]         cur_q, cur_d;

  logic [7:0] src_rise;
  logic [7:0] eligible;
  logic [7:0] set_bits;
  logic [7:0] clr_bits;
  logic [2:0] sel;
  logic       has_elig;
  logic       wr_ctrl, wr_stat;
  logic       unused_data;

  assign src_rise = 8'(s2_q & ~s3_q);
  assign eligible = pend_q & mask_q;
  assign has_elig = |eligible;
  assign wr_ctrl  = stb & we & ~addr;
  assign wr_stat  = stb & we & addr;

  assign unused_data = ^data_in[30:8];

  // Lowest eligible index wins; selection is 7 when nothing is eligible (spurious acknowledge).
  always_comb begin
    sel = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  always_comb begin
    set_bits = src_rise;
    clr_bits = 8'h00;
    if (wr_stat) begin
      if (data_in[31]) set_bits = set_bits | data_in[7:0];
      else             clr_bits = data_in[7:0];
    end
    if (intack && has_elig) clr_bits = clr_bits | (8'h01 << sel);
  end

  // Sets are OR-ed in after clears so a coincident event is never lost.
  always_comb begin
    mask_d  = mask_q;
    gen_d   = gen_q;
    insvc_d = insvc_q;
    spur_d  = spur_q;
    cur_d   = cur_q;
    pend_d  = ((pend_q & ~clr_bits) | set_bits) & SRC_MASK;
    if (wr_ctrl) begin
      mask_d = data_in[7:0] & SRC_MASK;
      gen_d  = data_in[31];
    end
    if (rti) begin
      insvc_d = 1'b0;
      spur_d  = 1'b0;
    end
    if (intack) begin
      insvc_d = 1'b1;
      cur_d   = sel;
      spur_d  = ~has_elig;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      mask_q  <= 8'h00;
      pend_q  <= 8'h00;
      gen_q   <= 1'b0;
      insvc_q <= 1'b0;
      spur_q  <= 1'b0;
      cur_q   <= 3'd0;
    end else begin
      s1_q    <= src;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      gen_q   <= gen_d;
      insvc_q <= insvc_d;
      spur_q  <= spur_d;
      cur_q   <= cur_d;
    end
  end

  always_comb begin
    data_out = 32'h0;
    if (stb) begin
      if (addr) data_out = {insvc_q, spur_q, 27'b0, cur_q};
      else      data_out = {gen_q, 15'b0, pend_q, mask_q};
    end
  end

  assign ack     = stb;
  assign irq     = gen_q & ~insvc_q & has_elig;
  assign cur_src = cur_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: drivers push expected values, a negedge monitor
// pops and compares whenever an observation is presented.
module tb_irq_ctrl;

  localparam int K_RD   = 0;
  localparam int K_IRQ  = 1;
  localparam int K_IDLE = 2;
  localparam int K_CUR  = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stb = 1'b0, we = 1'b0, addr = 1'b0;
  logic [31:0] data_in = 32'h0;
  logic [7:0]  src = 8'h00;
  logic        intack = 1'b0, rti = 1'b0;
  logic [31:0] data_out;
  logic        ack, irq;
  logic [2:0]  cur_src;

  irq_ctrl #(.num_irq(8)) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .src(src), .intack(intack), .rti(rti),
    .data_out(data_out), .ack(ack), .irq(irq), .cur_src(cur_src)
  );

  // scoreboard
  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];
  logic        obs_v = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    logic [31:0] e, act;
    int          k;
    string       nm;
    bit          ok;
    if (obs_v) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL underflow: observation with empty expected queue");
      end else begin
        e  = exp_q.pop_front();
        k  = kind_q.pop_front();
        nm = name_q.pop_front();
        act = 32'h0;
        ok  = 1'b0;
        case (k)
          K_RD:   begin act = data_out;           ok = (data_out === e) && (ack === 1'b1); end
          K_IRQ:  begin act = {31'b0, irq};       ok = (irq === e[0]); end
          K_IDLE: begin act = data_out;           ok = (data_out === e) && (ack === 1'b0); end
          default: begin act = {29'b0, cur_src}; ok = (cur_src === e[2:0]); end
        endcase
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got %h ack=%b expected %h", nm, act, ack, e);
        end
      end
    end
  end

  // driver tasks (entered and left at #1 after a rising edge)
  task automatic observe(input int k, input logic [31:0] v, input string nm);
    exp_q.push_back(v);
    kind_q.push_back(k);
    name_q.push_back(nm);
    obs_v = 1'b1;
    @(posedge clk); #1;
    obs_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; data_in = 32'h0;
  endtask

  task automatic rd(input logic a, input logic [31:0] v, input string nm);
    stb = 1'b1; we = 1'b0; addr = a;
    observe(K_RD, v, nm);
    stb = 1'b0;
  endtask

  task automatic chk_irq(input logic v, input string nm);
    observe(K_IRQ, {31'b0, v}, nm);
  endtask

  task automatic do_intack();
    intack = 1'b1; @(posedge clk); #1; intack = 1'b0;
  endtask

  task automatic do_rti();
    rti = 1'b1; @(posedge clk); #1; rti = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] m);
    src = src | m;
    idle(2);
    src = src & ~m;
  endtask

  initial begin
    // reset state
    idle(1);
    observe(K_IDLE, 32'h0, "reset_bus");
    chk_irq(1'b0, "reset_irq");
    rst_n = 1'b1;
    idle(1);
    rd(1'b0, 32'h0000_0000, "post_reset_ctrl");
    observe(K_CUR, 32'h0, "post_reset_cur");

    // build state, then asynchronous reset mid-cycle
    wr(1'b0, 32'h8000_00FF);
    wr(1'b1, 32'h8000_0008);
    chk_irq(1'b1, "pre_rst_irq");
    do_intack();
    rd(1'b1, 32'h8000_0003, "pre_rst_status");
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(1'b0, 32'h0000_0000, "rst_ctrl");
    rd(1'b1, 32'h0000_0000, "rst_status");
    chk_irq(1'b0, "rst_irq");
    observe(K_CUR, 32'h0, "rst_cur");
    pulse_src(8'h01);
    idle(1);
    chk_irq(1'b0, "gen0_irq");
    rd(1'b0, 32'h0000_0100, "gen0_pend");
    wr(1'b1, 32'h0000_00FF);

    // basic service
    wr(1'b0, 32'h8000_00FF);
    pulse_src(8'h08);
    chk_irq(1'b0, "latency_early");
    chk_irq(1'b1, "latency_irq");
    do_intack();
    chk_irq(1'b0, "ack_irq_low");
    rd(1'b1, 32'h8000_0003, "ack_status");
    rd(1'b0, 32'h8000_00FF, "ack_pend_clr");
    observe(K_CUR, 32'h3, "ack_cur");
    do_rti();
    rd(1'b1, 32'h0000_0003, "rti_status");

    // priority
    pulse_src(8'h24);
    idle(1);
    chk_irq(1'b1, "prio_irq");
    rd(1'b0, 32'h8000_24FF, "prio_pend");
    do_intack();
    rd(1'b1, 32'h8000_0002, "prio_first");
    rd(1'b0, 32'h8000_20FF, "prio_pend_after1");
    chk_irq(1'b0, "prio_insvc_irq");
    do_rti();
    chk_irq(1'b1, "prio_reraise");
    do_intack();
    rd(1'b1, 32'h8000_0005, "prio_second");
    rd(1'b0, 32'h8000_00FF, "prio_pend_empty");
    do_rti();

    // mask and spurious acknowledge
    wr(1'b0, 32'h8000_0000);
    wr(1'b1, 32'h8000_0010);
    chk_irq(1'b0, "masked_irq");
    rd(1'b0, 32'h8000_1000, "sw_set_pend");
    wr(1'b0, 32'h8000_0010);
    chk_irq(1'b1, "unmasked_irq");
    wr(1'b0, 32'h0000_0000);
    chk_irq(1'b0, "gen_off_irq");
    do_intack();
    rd(1'b1, 32'hC000_0007, "spur_status");
    rd(1'b0, 32'h0000_1000, "spur_pend_kept");
    do_rti();
    rd(1'b1, 32'h0000_0007, "spur_rti_status");
    wr(1'b1, 32'h0000_00FF);

    // W1C colliding with a source edge on the same bit
    src[0] = 1'b1;
    idle(2);
    src[0] = 1'b0;
    wr(1'b1, 32'h0000_0001);
    rd(1'b0, 32'h0000_0100, "w1c_vs_edge");
    wr(1'b1, 32'h0000_0001);
    rd(1'b0, 32'h0000_0000, "w1c_alone");

    // intack and rti together; no nesting while in service
    wr(1'b1, 32'h8000_0040);
    wr(1'b0, 32'h8000_00FF);
    do_intack();
    rd(1'b1, 32'h8000_0006, "svc6_status");
    wr(1'b1, 32'h8000_0002);
    chk_irq(1'b0, "no_nesting");
    intack = 1'b1; rti = 1'b1;
    @(posedge clk); #1;
    intack = 1'b0; rti = 1'b0;
    rd(1'b1, 32'h8000_0001, "ack_rti_same");
    rd(1'b0, 32'h8000_00FF, "ack_rti_pend");
    do_rti();
    rd(1'b1, 32'h0000_0001, "ack_rti_done");

    // mask write in the same cycle as intack uses the old mask
    wr(1'b1, 32'h8000_0004);
    stb = 1'b1; we = 1'b1; addr = 1'b0; data_in = 32'h8000_0000; intack = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0; data_in = 32'h0; intack = 1'b0;
    rd(1'b1, 32'h8000_0002, "old_mask_sel");
    rd(1'b0, 32'h8000_0000, "old_mask_ctrl");
    do_rti();

    // level-high source sets pending once per rising edge
    wr(1'b0, 32'h0000_0000);
    src[1] = 1'b1;
    idle(5);
    rd(1'b0, 32'h0000_0200, "level_set");
    wr(1'b1, 32'h0000_0002);
    idle(95);
    rd(1'b0, 32'h0000_0000, "level_held");
    src[1] = 1'b0;
    idle(3);
    rd(1'b0, 32'h0000_0000, "level_fall");
    src[1] = 1'b1;
    idle(4);
    rd(1'b0, 32'h0000_0200, "level_rerise");
    src[1] = 1'b0;

    idle(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Vectored interrupt controller driving the RISC5 CPU `irq` input, with a mask and priority select for up to 8 hardware event sources (ms timer tick, RS232 rx/tx, SPI, proc timers, …). It tracks in-service state via the CPU's `intack`/`rti` extension signals. It is a standard IO device on two consecutive IO addresses, -40 (ctrl) and -36 (status), decoded by the top level.

## Interface
- `num_irq`, 8: number of sources, 1..8; unused bits of the 8-bit fields read 0.
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stb` in 1: device select from IO decode.
- `we` in 1: write strobe (CPU `wr`).
- `addr` in 1: `adr[2]`; 0 = ctrl, 1 = status.
- `data_in` in 32: CPU outbus.
- `src` in num_irq: asynchronous event sources, rising-edge sensitive.
- `intack` in 1: CPU interrupt acknowledge, 1-cycle pulse.
- `rti` in 1: CPU return-from-interrupt, 1-cycle pulse.
- `data_out` out 32: register read data, combinational from `addr`.
- `ack` out 1: equals `stb`, combinational.
- `irq` out 1: interrupt request to the CPU.
- `cur_src` out 3: number of the source being serviced, for logging.

## Operation
- **State:**
  - `mask[7:0]`
  - `gen` (global enable)
  - `pend[7:0]`
  - `insvc`
  - `spur`
  - `cur[2:0]`
  - per-source synchroniser `s1`, `s2`, `s3`
- **Reset value:** all state is 0. Therefore `irq` = 0, `cur_src` = 0, and `data_out` = 0 when `stb` = 0.
- **Edge detect:** `s1 <= src`, `s2 <= s1`, `s3 <= s2`. `edge[i] = s2[i] & ~s3[i]`. Level-high sources set pending once per rising edge only.
- **Write ctrl (addr 0):**
  - `mask <= data_in[num_irq-1:0]`
  - `gen <= data_in[31]`
- **Write status (addr 1):**
  - If `data_in[31]` = 0: `pend <= pend & ~data_in[7:0]` (write-1-to-clear).
  - If `data_in[31]` = 1: `pend <= pend | data_in[7:0]` (software trigger).
- **Read ctrl:** `{gen, 15'b0, pend[7:0], mask[7:0]}`.
- **Read status:** `{insvc, spur, 27'b0, cur[2:0]}`.
- **Request:** `irq = gen & ~insvc & |(pend & mask)`. This is combinational from registers and glitch-free at the CPU sample point.
- **Acknowledge:** on `intack`:
  - `insvc <= 1`.
  - `cur <=` lowest index `i` with `pend[i] & mask[i]`.
  - `pend[i] <= 0`.
  - If no eligible bit (request withdrawn in the same cycle): `spur <= 1`, `cur <= 7`, `pend` unchanged.
- **Return:** on `rti`: `insvc <= 0`, `spur <= 0`. `cur` holds its value until the next `intack`. Remaining eligible pending bits re-raise `irq` the cycle after.
- **Priority:** fixed; bit 0 highest. No nesting: while `insvc` = 1, `irq` stays 0 regardless of new pendings.
- **Simultaneous events, per bit:**
  - set (edge or software) beats clear (W1C or `intack` clear), so no event is lost.
  - `intack` and `rti` in the same cycle: `rti` is applied first, then `intack`, so `insvc` ends at 1.
  - CPU write to mask in the same cycle as `intack`: selection uses the old `mask`.
- **Reset mid-service:** `rst_n` low clears `insvc`, `pend` and synchronisers immediately and asynchronously. Edges in flight are lost.

## Timing
- **Edge to pending:** `src` high sampled at edge k → `edge` true after k+1 → `pend` set at k+2 → `irq` high after k+2 (2-cycle latency plus sampling uncertainty).
- **Acknowledge:** `intack` at edge m → `irq` low after m (`insvc` set). Registers read back the new values from cycle m+1.
- **Return:** `rti` at edge r → `irq` may reassert after r.
- **Writes:** register writes take effect at the same edge as `stb & we`. `ack` has zero wait states.
- **Minimum pulse:** `src` pulses shorter than one `clk` period may be missed. Sources must hold high ≥ 1 cycle and low ≥ 1 cycle between events.

## Test plan
- **Reset:** pulse `rst_n` low mid-cycle, release; pulse `src[0]`.
  - All reads = 0.
  - `irq` = 0 (`gen` = 0), but ctrl read shows `pend` = 0x01.
- **Basic service:**
  - Write ctrl 0x8000_00FF, pulse `src[3]` → `irq` high 2 cycles after sample.
  - `intack` → `irq` low; status reads 0x8000_0003; `pend[3]` = 0.
  - `rti` → status 0x0000_0003.
- **Priority:**
  - With `mask` = 0xFF and `gen` = 1, pulse `src[5]` and `src[2]` together.
  - First `intack` → `cur` = 2; `rti` → `irq` high next cycle.
  - Second `intack` → `cur` = 5, `pend` = 0.
- **Mask/spurious:**
  - `mask` = 0x00, software-set `pend` = 0x10 (write status 0x8000_0010) → `irq` = 0.
  - Write `mask` = 0x10 → `irq` = 1.
  - Force `intack` with `gen` = 0 → status 0xC000_0007.
- **Collision:**
  - W1C 0x01 in the same cycle as `edge[0]` → `pend[0]` remains 1.
  - `intack` and `rti` in the same cycle → `insvc` = 1.
- **Level source:** hold `src[1]` high 100 cycles → exactly one `pend[1]` set; after clear it stays 0 until `src[1]` falls and rises again.
